// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage pipeline. It takes the EX/MEM entry and runs a
// req/ack transaction against data memory for loads and stores. While that
// transaction is outstanding it stalls the front of the pipeline. It also
// resolves branches (pc_src) and registers the MEM/WB entry. Misaligned
// accesses, read+write accesses and memory timeouts complete with err_out set
// and RegWrite cleared.
//
// Parameters
//   TIMEOUT   BUSY cycles without dmem_ack before the access is aborted
//   CNT_W     width of the wait counter
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   ex_valid           EX/MEM entry valid (0 = bubble)
//   wb_in[1:0]         {RegWrite, MemtoReg}
//   mem_in[2:0]        {Branch, MemWrite, MemRead}
//   alu_in, wd_in      ALU result / byte address, store data
//   wn_in, zero_in,    destination register, ALU zero flag,
//   jal_in             JAL marker
//   dmem_*             data-memory request channel
//   stall              hold PC/IF/ID/ID/EX/EX/MEM this cycle
//   pc_src             take branch (combinational)
//   valid_out ..       registered MEM/WB entry
//   err_out            one-cycle error flag for the completing instruction
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  wb_in,
    input  logic [2:0]  mem_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] wd_in,
    input  logic [4:0]  wn_in,
    input  logic        zero_in,
    input  logic        jal_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic        valid_out,
    output logic [1:0]  wb_out,
    output logic [31:0] rd_data_out,
    output logic [31:0] alu_out,
    output logic [4:0]  wn_out,
    output logic        jal_out,
    output logic        err_out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] wait_cnt;

    // Transaction hold registers, loaded when a legal access is accepted.
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;
    logic        hold_rd;
    logic [1:0]  hold_wb;
    logic [4:0]  hold_wn;
    logic        hold_jal;

    logic memop;
    logic legal;
    logic accept;
    logic illegal;
    logic timeout_hit;

    assign memop       = ex_valid & (mem_in[1] | mem_in[0]);
    assign legal       = (alu_in[1:0] == 2'b00) & ~(mem_in[1] & mem_in[0]);
    assign accept      = (state == IDLE) & memop & legal;
    assign illegal     = (state == IDLE) & memop & ~legal;
    // Last allowed BUSY cycle: without an ack here the access is aborted.
    assign timeout_hit = (state == BUSY) & (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign dmem_addr  = hold_addr;
    assign dmem_wdata = hold_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        stall     = 1'b0;
        pc_src    = 1'b0;
        case (state)
            IDLE: begin
                pc_src = ex_valid & mem_in[2] & zero_in;
                stall  = accept;
                if (accept) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                dmem_req = 1'b1;
                dmem_we  = hold_we;
                stall    = ~dmem_ack & ~timeout_hit;
                if (dmem_ack || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Combinational outputs must be quiet for the whole reset interval,
        // not only after the next clock edge.
        if (!rst) begin
            stall  = 1'b0;
            pc_src = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            hold_we     <= 1'b0;
            hold_rd     <= 1'b0;
            hold_wb     <= '0;
            hold_wn     <= '0;
            hold_jal    <= 1'b0;
            valid_out   <= 1'b0;
            wb_out      <= '0;
            rd_data_out <= '0;
            alu_out     <= '0;
            wn_out      <= '0;
            jal_out     <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            // Default MEM/WB content is a bubble.
            valid_out   <= 1'b0;
            wb_out      <= '0;
            rd_data_out <= '0;
            alu_out     <= '0;
            wn_out      <= '0;
            jal_out     <= 1'b0;
            err_out     <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    wait_cnt   <= '0;
                    hold_addr  <= alu_in;
                    hold_wdata <= wd_in;
                    hold_we    <= mem_in[1];
                    hold_rd    <= mem_in[0];
                    hold_wb    <= wb_in;
                    hold_wn    <= wn_in;
                    hold_jal   <= jal_in;
                end else if (illegal) begin
                    valid_out <= 1'b1;
                    wb_out    <= {1'b0, wb_in[0]};
                    alu_out   <= alu_in;
                    wn_out    <= wn_in;
                    jal_out   <= jal_in;
                    err_out   <= 1'b1;
                end else begin
                    valid_out <= ex_valid;
                    wb_out    <= ex_valid ? wb_in : 2'b00;
                    alu_out   <= alu_in;
                    wn_out    <= wn_in;
                    jal_out   <= jal_in;
                end
            end else begin
                if (dmem_ack) begin
                    valid_out   <= 1'b1;
                    wb_out      <= hold_wb;
                    rd_data_out <= hold_rd ? dmem_rdata : 32'h0;
                    alu_out     <= hold_addr;
                    wn_out      <= hold_wn;
                    jal_out     <= hold_jal;
                end else if (timeout_hit) begin
                    valid_out <= 1'b1;
                    wb_out    <= {1'b0, hold_wb[0]};
                    alu_out   <= hold_addr;
                    wn_out    <= hold_wn;
                    jal_out   <= hold_jal;
                    err_out   <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  wb_in;
    logic [2:0]  mem_in;
    logic [31:0] alu_in;
    logic [31:0] wd_in;
    logic [4:0]  wn_in;
    logic        zero_in;
    logic        jal_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        pc_src;
    logic        valid_out;
    logic [1:0]  wb_out;
    logic [31:0] rd_data_out;
    logic [31:0] alu_out;
    logic [4:0]  wn_out;
    logic        jal_out;
    logic        err_out;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .wb_in(wb_in),
        .mem_in(mem_in), .alu_in(alu_in), .wd_in(wd_in), .wn_in(wn_in),
        .zero_in(zero_in), .jal_in(jal_in), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .pc_src(pc_src), .valid_out(valid_out), .wb_out(wb_out),
        .rd_data_out(rd_data_out), .alu_out(alu_out), .wn_out(wn_out),
        .jal_out(jal_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Transaction view: an accepted access waits in memory until it is
    // acknowledged or has spent TO cycles outstanding.
    logic        m_busy;
    int          m_waited;
    logic [31:0] t_addr, t_wdata;
    logic        t_we, t_rd, t_jal;
    logic [1:0]  t_wb;
    logic [4:0]  t_wn;
    // expected MEM/WB after the coming edge
    logic        e_valid, e_jal, e_err;
    logic [1:0]  e_wb;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wn;

    task automatic m_writeback(input logic v, input logic [1:0] wb, input logic [31:0] rd,
                               input logic [31:0] alu, input logic [4:0] wn,
                               input logic jal, input logic err);
        e_valid = v; e_wb = wb; e_rd = rd; e_alu = alu; e_wn = wn; e_jal = jal; e_err = err;
    endtask

    always @(negedge clk) begin
        logic rw_both, aligned, is_mem, last_try;
        if (!rst) begin
            chk("rst_valid", 32'(valid_out), 0);
            chk("rst_wb", 32'(wb_out), 0);
            chk("rst_rd", rd_data_out, 0);
            chk("rst_alu", alu_out, 0);
            chk("rst_wn", 32'(wn_out), 0);
            chk("rst_jal", 32'(jal_out), 0);
            chk("rst_err", 32'(err_out), 0);
            chk("rst_req", 32'(dmem_req), 0);
            chk("rst_we", 32'(dmem_we), 0);
            chk("rst_stall", 32'(stall), 0);
            chk("rst_pcsrc", 32'(pc_src), 0);
            m_busy = 1'b0;
            m_waited = 0;
            m_writeback(0, 0, 0, 0, 0, 0, 0);
        end else begin
            chk("valid_out", 32'(valid_out), 32'(e_valid));
            chk("wb_out", 32'(wb_out), 32'(e_wb));
            chk("rd_data_out", rd_data_out, e_rd);
            chk("alu_out", alu_out, e_alu);
            chk("wn_out", 32'(wn_out), 32'(e_wn));
            chk("jal_out", 32'(jal_out), 32'(e_jal));
            chk("err_out", 32'(err_out), 32'(e_err));
            if (!m_busy) begin
                is_mem   = ex_valid && (mem_in[1] || mem_in[0]);
                aligned  = (alu_in % 4) == 0;
                rw_both  = mem_in[1] && mem_in[0];
                chk("req_idle", 32'(dmem_req), 0);
                chk("we_idle", 32'(dmem_we), 0);
                chk("stall_idle", 32'(stall), 32'(is_mem && aligned && !rw_both));
                chk("pc_src", 32'(pc_src), 32'(ex_valid && mem_in[2] && zero_in));
                if (is_mem && aligned && !rw_both) begin
                    m_busy = 1'b1; m_waited = 0;
                    t_addr = alu_in; t_wdata = wd_in; t_we = mem_in[1]; t_rd = mem_in[0];
                    t_wb = wb_in; t_wn = wn_in; t_jal = jal_in;
                    m_writeback(0, 0, 0, 0, 0, 0, 0);
                end else if (is_mem) begin
                    m_writeback(1, {1'b0, wb_in[0]}, 0, alu_in, wn_in, jal_in, 1);
                end else begin
                    m_writeback(ex_valid, ex_valid ? wb_in : 2'b00, 0, alu_in, wn_in, jal_in, 0);
                end
            end else begin
                last_try = (m_waited == TO - 1);
                chk("req_busy", 32'(dmem_req), 1);
                chk("we_busy", 32'(dmem_we), 32'(t_we));
                chk("addr_busy", dmem_addr, t_addr);
                chk("wdata_busy", dmem_wdata, t_wdata);
                chk("stall_busy", 32'(stall), 32'(!dmem_ack && !last_try));
                chk("pc_src_busy", 32'(pc_src), 0);
                if (dmem_ack) begin
                    m_busy = 1'b0;
                    m_writeback(1, t_wb, t_rd ? dmem_rdata : 32'h0, t_addr, t_wn, t_jal, 0);
                end else if (last_try) begin
                    m_busy = 1'b0;
                    m_writeback(1, {1'b0, t_wb[0]}, 0, t_addr, t_wn, t_jal, 1);
                end else begin
                    m_waited++;
                    m_writeback(0, 0, 0, 0, 0, 0, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] mem,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wn, input logic z, input logic j);
        ex_valid = v; wb_in = wb; mem_in = mem; alu_in = alu; wd_in = wd;
        wn_in = wn; zero_in = z; jal_in = j;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n_st, n_rq;
        logic [31:0] r;
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        // a legal load presented during reset must not raise stall
        drive(1, 2'b11, 3'b001, 32'h0, 0, 3, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_stall", 32'(stall), 0);
        chk("lit_rst_valid", 32'(valid_out), 0);

        // R-type pass-through
        tick();
        rst = 1'b1;
        drive(1, 2'b10, 3'b000, 32'h1234, 0, 5, 0, 0);
        @(negedge clk);
        chk("lit_rtype_stall", 32'(stall), 0);
        tick();
        bubble();
        @(negedge clk);
        chk("lit_rtype_valid", 32'(valid_out), 1);
        chk("lit_rtype_alu", alu_out, 32'h1234);
        chk("lit_rtype_wn", 32'(wn_out), 5);
        chk("lit_rtype_wb", 32'(wb_out), 2);

        // Load 0x40, ack in the third BUSY cycle
        tick();
        drive(1, 2'b11, 3'b001, 32'h40, 0, 7, 0, 0);
        n_st = 0; n_rq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (stall) n_st++;
            if (dmem_req) begin
                n_rq++;
                chk("lit_load_addr", dmem_addr, 32'h40);
            end
            tick();
            bubble();
            dmem_ack = (i == 2);
            dmem_rdata = (i == 2) ? 32'hDEADBEEF : 32'h0;
        end
        @(negedge clk);
        chk("lit_load_valid", 32'(valid_out), 1);
        chk("lit_load_rdata", rd_data_out, 32'hDEADBEEF);
        chk("lit_load_wb", 32'(wb_out), 3);
        chk("lit_load_stall_cnt", 32'(n_st), 3);
        chk("lit_load_req_cnt", 32'(n_rq), 3);

        // Store 0x44, ack in the first BUSY cycle
        tick();
        dmem_ack = 1'b0;
        drive(1, 2'b00, 3'b010, 32'h44, 32'hA5A5A5A5, 0, 0, 0);
        @(negedge clk);
        n_st = stall ? 1 : 0;
        tick();
        bubble();
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("lit_store_we", 32'(dmem_we), 1);
        chk("lit_store_wdata", dmem_wdata, 32'hA5A5A5A5);
        if (stall) n_st++;
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("lit_store_stall_cnt", 32'(n_st), 1);
        chk("lit_store_rd", rd_data_out, 0);
        chk("lit_store_valid", 32'(valid_out), 1);

        // Misaligned load 0x42
        tick();
        drive(1, 2'b11, 3'b001, 32'h42, 0, 9, 0, 0);
        @(negedge clk);
        chk("lit_mis_req", 32'(dmem_req), 0);
        chk("lit_mis_stall", 32'(stall), 0);
        tick();
        bubble();
        @(negedge clk);
        chk("lit_mis_err", 32'(err_out), 1);
        chk("lit_mis_valid", 32'(valid_out), 1);
        chk("lit_mis_regwrite", 32'(wb_out[1]), 0);

        // Timeout: never ack
        tick();
        drive(1, 2'b11, 3'b001, 32'h80, 0, 4, 0, 0);
        n_rq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dmem_req) n_rq++;
            if (i == 4) chk("lit_to_last_stall", 32'(stall), 0);
            tick();
            bubble();
        end
        @(negedge clk);
        chk("lit_to_req_cnt", 32'(n_rq), TO);
        chk("lit_to_req_drop", 32'(dmem_req), 0);
        chk("lit_to_err", 32'(err_out), 1);
        chk("lit_to_regwrite", 32'(wb_out[1]), 0);
        chk("lit_to_stall", 32'(stall), 0);

        // Branch taken in IDLE
        tick();
        drive(1, 2'b00, 3'b100, 32'h0, 0, 0, 1, 0);
        @(negedge clk);
        chk("lit_branch_pcsrc", 32'(pc_src), 1);

        // Reset in the middle of BUSY, then a late ack
        tick();
        drive(1, 2'b11, 3'b001, 32'h10, 0, 2, 0, 0);
        tick();
        bubble();
        #2;
        rst = 1'b0;
        #1;
        chk("lit_mid_rst_req", 32'(dmem_req), 0);
        chk("lit_mid_rst_stall", 32'(stall), 0);
        chk("lit_mid_rst_valid", 32'(valid_out), 0);
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12345678;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("lit_late_ack_req", 32'(dmem_req), 0);
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("lit_late_ack_valid", 32'(valid_out), 0);
        chk("lit_late_ack_rd", rd_data_out, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            r = $urandom;
            ex_valid = (r[3:0] != 0);
            wb_in = 2'($urandom);
            mem_in = 3'($urandom);
            alu_in = $urandom;
            if (r[5:4] != 0) alu_in[1:0] = 2'b00;
            wd_in = $urandom;
            wn_in = 5'($urandom);
            zero_in = r[6];
            jal_in = r[7];
            dmem_ack = ($urandom_range(0, 99) < 35);
            dmem_rdata = $urandom;
            rst = ($urandom_range(0, 299) != 0);
        end
        tick();
        rst = 1'b1;
        bubble();
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
